// File: rtl/arith_sched_pkg.sv
// Shared constants and FSM state type for the arithmetic scheduler.
package arith_sched_pkg;
  localparam int RES_W = 32;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL2 = 2'd2,
    S_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/arith_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above rr_ptr, wrapping.
module arith_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);
  always_comb begin
    int  idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arith_scheduler.sv
// Shares one signed add/sub/mul datapath among N_REQ requesters.
// Define ARITH_SCHED_MUL_PIPE_EN to split multiplies over EXEC and MUL2.
module arith_scheduler
  import arith_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [16*N_REQ-1:0] req_a,
  input  logic [16*N_REQ-1:0] req_b,
  input  logic [2*N_REQ-1:0]  req_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [RES_W-1:0]    rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic [15:0]         ops_done
);
  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_id;
  logic [15:0]        op_a;
  logic [15:0]        op_b;
  logic [1:0]         op_code;
  logic [ID_W-1:0]    op_id;
  logic [RES_W-1:0]   a_ext;
  logic [RES_W-1:0]   b_ext;
  logic [RES_W-1:0]   alu_res;
  logic               accept;
`ifdef ARITH_SCHED_MUL_PIPE_EN
  logic [RES_W-1:0]   prod_reg;
`endif

  arith_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req      (req_valid),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Ready is gated by rst_n so it is low for the whole reset, not just after an edge.
  assign req_ready = (rst_n && state == S_IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != S_IDLE);

  assign a_ext = {{16{op_a[15]}}, op_a};
  assign b_ext = {{16{op_b[15]}}, op_b};

  always_comb begin
    alu_res = '0;
    case (op_code)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_MUL:  alu_res = RES_W'($signed(a_ext) * $signed(b_ext));
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= OP_ADD;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      ops_done  <= '0;
`ifdef ARITH_SCHED_MUL_PIPE_EN
      prod_reg  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a    <= req_a[16*int'(grant_id) +: 16];
            op_b    <= req_b[16*int'(grant_id) +: 16];
            op_code <= req_op[2*int'(grant_id) +: 2];
            op_id   <= grant_id;
            rr_ptr  <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_id  <= op_id;
          rsp_err <= (op_code == OP_RSVD);
`ifdef ARITH_SCHED_MUL_PIPE_EN
          if (op_code == OP_MUL) begin
            prod_reg <= alu_res;
            state    <= S_MUL2;
          end else begin
            rsp_data  <= alu_res;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end
`else
          rsp_data  <= alu_res;
          rsp_valid <= 1'b1;
          state     <= S_DONE;
`endif
        end
`ifdef ARITH_SCHED_MUL_PIPE_EN
        S_MUL2: begin
          rsp_data  <= prod_reg;
          rsp_valid <= 1'b1;
          state     <= S_DONE;
        end
`endif
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/arith_scheduler.md
# arith_scheduler

Shares a single signed 16-bit add/sub/mul datapath among `N_REQ` requesters. Each requester presents operands and an opcode over a valid/ready handshake. A round-robin arbiter picks one requester and the operation is executed. The 32-bit result is returned tagged with the requester index over a valid/ready response channel. The block sits between the software-facing register slices and the arithmetic resource, so the datapath is never driven by more than one source at a time.

## Interface
- `N_REQ`, 4 — number of requesters; 2..8.
- `ID_W`, 2 — width of the requester index; must equal clog2(`N_REQ`).
- `clk` in 1 — single clock; all logic is on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset; deassertion is synchronised externally.
- `req_valid` in `N_REQ` — per-requester request valid.
- `req_ready` out `N_REQ` — per-requester accept; at most one bit is high.
- `req_a` in 16·`N_REQ` — signed operand A, packed; requester i uses bits [16i+15:16i].
- `req_b` in 16·`N_REQ` — signed operand B, packed.
- `req_op` in 2·`N_REQ` — opcode: 00 add, 01 sub, 10 mul, 11 reserved.
- `rsp_valid` out 1 — response valid.
- `rsp_ready` in 1 — response accept.
- `rsp_id` out `ID_W` — index of the requester that issued the operation.
- `rsp_data` out 32 — result.
- `rsp_err` out 1 — high when the opcode was 11.
- `busy` out 1 — high whenever the state is not IDLE.
- `ops_done` out 16 — count of completed response handshakes; wraps from FFFF to 0000.

## Operation
- FSM states are IDLE, EXEC, MUL2 and DONE.
- **IDLE:**
  - The arbiter grants the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping at `N_REQ`.
  - `req_ready[grant]` is driven combinationally in the same cycle.
  - On valid&ready, the block latches A, B, op and id, sets `rr_ptr` to grant+1 (mod `N_REQ`) and moves to EXEC.
  - With no valid request, the state stays IDLE and `rr_ptr` is unchanged.
- **EXEC:**
  - For add/sub, the result register receives the operands sign-extended to 32 bits and combined. The sum is exact, so there is no overflow.
  - For mul, the result register receives the signed 16×16 product as a 32-bit value.
  - Opcode 11 gives data 0 and `rsp_err`=1.
  - Next state is DONE, or MUL2 for a mul when the Configuration macro is defined.
- **MUL2:** second multiply stage; next state is DONE.
- **DONE:**
  - `rsp_valid`=1; `rsp_data`, `rsp_id` and `rsp_err` are held stable.
  - On `rsp_ready`, `ops_done` increments and the state returns to IDLE.
- `req_ready` is all-zero in every state except IDLE. A request is never accepted in the same cycle as a response handshake.
- A requester that drops `req_valid` before it is granted loses its turn without any side effects.
- **Reset:**
  - Assertion of `rst_n`, including mid-operation, immediately clears all outputs and state.
  - The in-flight operation is discarded.
  - Reset values: state IDLE, `rr_ptr`=0, `req_ready`=0 (forced while `rst_n` is low), `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0, `busy`=0, `ops_done`=0.

## Timing
- Accept at cycle T gives `rsp_valid` at T+2 for add, sub, reserved, and mul without the macro.
- Mul with the macro gives `rsp_valid` at T+3.
- After a response handshake at cycle R, the earliest next accept is R+1.
- Peak throughput is one operation per 3 cycles (4 for a pipelined mul).
- Fairness: with all requesters continuously valid, each is served exactly once per `N_REQ` responses.
- `rsp_*` outputs and `ops_done` are registered. `req_ready` is combinational from `req_valid`, `rr_ptr` and the state.

## Configuration
- The macro is `ARITH_SCHED_MUL_PIPE_EN`.
- **Defined:** a mul is split across EXEC and MUL2 (product register, then output register) for timing closure on DSP48 (latency 3). Add, sub and reserved are unaffected.
- **Undefined:** MUL2 is unreachable and removed; mul completes in EXEC (latency 2).

## Structure
- `arith_sched_pkg` holds:
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_MUL` and `OP_RSVD`;
  - the FSM state enum;
  - the 32-bit result width constant.
- One sub-module, `arith_rr_arbiter`:
  - parameterised by `N_REQ`;
  - inputs are the request vector and `rr_ptr`;
  - outputs are a one-hot grant and the encoded grant id;
  - purely combinational.
- The pointer register lives in the top level.

## Test plan
- **Add, max positive plus one:** requester 0 add, A=7FFF, B=0001, accept at T. Expect `rsp_valid` at T+2, `rsp_data`=00008000, `rsp_id`=0, `rsp_err`=0.
- **Sub, negative result:** requester 2 sub, A=FFFB (−5), B=0003. Expect `rsp_data`=FFFFFFF8, `rsp_id`=2.
- **Mul, most-negative operands:** requester 1 mul, A=8000, B=8000. Expect `rsp_data`=40000000; latency T+2 without the macro, T+3 with it.
- **Round-robin fairness:** all 4 requesters valid continuously. Expect grant order 0,1,2,3,0,1; `ops_done`=6 after six responses.
- **Reserved opcode:** requester 3, op=11. Expect `rsp_err`=1, `rsp_data`=0, `rsp_id`=3.
- **Backpressure then reset:**
  - Hold `rsp_ready`=0 for 10 cycles in DONE. Expect outputs stable and `req_ready`=0.
  - Then assert `rst_n`=0 mid-EXEC of the next operation. Expect every output 0 immediately and first grant to requester 0 after release.
